fwd_select_reg: RTL

FWD_SELECT_REG -- requirements
Module: fwd_select_reg

---
 rtl/fwd_select_reg_if.sv | 24 ++
 rtl/fwd_select_reg.sv | 47 ++++
 2 files changed

// File: rtl/fwd_select_reg_if.sv
// fwd_select_reg_if: operand-forwarding bus; master drives sources/select/valid/stall/flush, slave returns data_o/valid_o/err_o/err_cnt_o
interface fwd_select_reg_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
);
  logic [NUM_SRC*WIDTH-1:0] data_i;
  logic [SEL_W-1:0]         select_i;
  logic                     valid_i;
  logic                     stall_i;
  logic                     flush_i;
  logic [WIDTH-1:0]         data_o;
  logic                     valid_o;
  logic                     err_o;
  logic [7:0]               err_cnt_o;
  modport master (
    output data_i, select_i, valid_i, stall_i, flush_i,
    input  data_o, valid_o, err_o, err_cnt_o
  );
  modport slave (
    input  data_i, select_i, valid_i, stall_i, flush_i,
    output data_o, valid_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/fwd_select_reg.sv
// fwd_select_reg: registered forwarding mux; clk_i/rst_i plus bus (slave) carrying sources, select, valid, stall, flush in and data/valid/sticky-error/error-count out
module fwd_select_reg #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fwd_select_reg_if.slave      bus
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] w_src [2**SEL_W];
  logic             w_legal;
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_src
    if (k < NUM_SRC) begin : g_v
      assign w_src[k] = bus.data_i[k*WIDTH +: WIDTH];
    end else begin : g_z
      assign w_src[k] = '0;
    end
  end
  assign w_legal = int'(bus.select_i) < NUM_SRC;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (bus.flush_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (!bus.stall_i) begin
      r_valid <= bus.valid_i;
      if (bus.valid_i && w_legal) r_data <= w_src[bus.select_i];
      if (bus.valid_i && !w_legal) begin
        r_err <= 1'b1;
        r_cnt <= r_cnt + 8'(r_cnt != 8'hff);
      end
    end
  end
  assign bus.data_o    = r_data;
  assign bus.valid_o   = r_valid;
  assign bus.err_o     = r_err;
  assign bus.err_cnt_o = r_cnt;
endmodule
